// File: rtl/pipe_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_pkg
// Brief   : Opcodes, ALUOp encodings and the control bundle carried down the
//           pipeline by pipe_ctrl_unit.
// Revision: 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Native ALUOp width; the top resizes to its ALUOP_W on output.
    localparam int ALUOP_MAX_W = 3;

    localparam logic [ALUOP_MAX_W-1:0] ALUOP_ADD = 3'b000;
    localparam logic [ALUOP_MAX_W-1:0] ALUOP_BR  = 3'b001;
    localparam logic [ALUOP_MAX_W-1:0] ALUOP_R   = 3'b010;
    localparam logic [ALUOP_MAX_W-1:0] ALUOP_I   = 3'b011;
    localparam logic [ALUOP_MAX_W-1:0] ALUOP_LUI = 3'b100;
    localparam logic [ALUOP_MAX_W-1:0] ALUOP_JAL = 3'b101;

    typedef struct packed {
        logic [ALUOP_MAX_W-1:0] aluop;
        logic                   alusrc;
        logic                   regwrite;
        logic                   memread;
        logic                   memwrite;
        logic                   memtoreg;
        logic                   illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic ctrl_t mk_ctrl(
        input logic [ALUOP_MAX_W-1:0] aluop,
        input logic                   alusrc,
        input logic                   regwrite,
        input logic                   memread,
        input logic                   memwrite,
        input logic                   memtoreg
    );
        ctrl_t c;
        c.aluop    = aluop;
        c.alusrc   = alusrc;
        c.regwrite = regwrite;
        c.memread  = memread;
        c.memwrite = memwrite;
        c.memtoreg = memtoreg;
        c.illegal  = 1'b0;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_unit_if
// Brief   : ID-stage request and per-stage control outputs of pipe_ctrl_unit.
// Revision: 1.0 - initial release
// ============================================================================
interface pipe_ctrl_unit_if #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
);
    logic              valid_i;
    logic [6:0]        op_i;
    logic [REG_AW-1:0] rs1_i;
    logic [REG_AW-1:0] rs2_i;
    logic [REG_AW-1:0] rd_i;
    logic              flush_i;
    logic              hold_i;

    logic               stall_o;
    logic               branch_o;
    logic               jump_o;
    logic               ex_valid_o;
    logic               ex_alusrc_o;
    logic               ex_illegal_o;
    logic [ALUOP_W-1:0] ex_aluop_o;
    logic [REG_AW-1:0]  ex_rd_o;
    logic               mem_memread_o;
    logic               mem_memwrite_o;
    logic               mem_regwrite_o;
    logic               mem_memtoreg_o;
    logic [REG_AW-1:0]  mem_rd_o;
    logic               wb_regwrite_o;
    logic               wb_memtoreg_o;
    logic [REG_AW-1:0]  wb_rd_o;
    logic [CNT_W-1:0]   bubble_cnt_o;

    modport slave (
        input  valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i, hold_i,
        output stall_o, branch_o, jump_o,
        output ex_valid_o, ex_alusrc_o, ex_illegal_o, ex_aluop_o, ex_rd_o,
        output mem_memread_o, mem_memwrite_o, mem_regwrite_o, mem_memtoreg_o, mem_rd_o,
        output wb_regwrite_o, wb_memtoreg_o, wb_rd_o,
        output bubble_cnt_o
    );

    modport master (
        output valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i, hold_i,
        input  stall_o, branch_o, jump_o,
        input  ex_valid_o, ex_alusrc_o, ex_illegal_o, ex_aluop_o, ex_rd_o,
        input  mem_memread_o, mem_memwrite_o, mem_regwrite_o, mem_memtoreg_o, mem_rd_o,
        input  wb_regwrite_o, wb_memtoreg_o, wb_rd_o,
        input  bubble_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_unit_decode.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_decode
// Brief   : Combinational opcode decoder producing the control bundle and the
//           register-use / branch / jump flags.
// Revision: 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int EXT_OPS = 0,
    parameter int ALUOP_W = 2
) (
    input  logic [6:0] i_op,
    output ctrl_t      o_ctrl,
    output logic       o_use_rs1,
    output logic       o_use_rs2,
    output logic       o_branch,
    output logic       o_jump
);

    // lui/jal encodings need three ALUOp bits; narrower builds treat them as illegal.
    localparam bit c_ext_en = (EXT_OPS != 0) && (ALUOP_W >= ALUOP_MAX_W);

    always_comb begin
        o_ctrl         = CTRL_NOP;
        o_ctrl.illegal = 1'b1;
        o_use_rs1      = 1'b0;
        o_use_rs2      = 1'b0;
        o_branch       = 1'b0;
        o_jump         = 1'b0;
        case (i_op)
            OP_ITYPE: begin
                o_ctrl    = mk_ctrl(ALUOP_I, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                o_use_rs1 = 1'b1;
            end
            OP_RTYPE: begin
                o_ctrl    = mk_ctrl(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                o_use_rs1 = 1'b1;
                o_use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl    = mk_ctrl(ALUOP_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
                o_use_rs1 = 1'b1;
            end
            OP_STORE: begin
                o_ctrl    = mk_ctrl(ALUOP_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                o_use_rs1 = 1'b1;
                o_use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl    = mk_ctrl(ALUOP_BR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                o_use_rs1 = 1'b1;
                o_use_rs2 = 1'b1;
                o_branch  = 1'b1;
            end
            OP_LUI: begin
                if (c_ext_en) begin
                    o_ctrl = mk_ctrl(ALUOP_LUI, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                end
            end
            OP_JAL: begin
                if (c_ext_en) begin
                    o_ctrl = mk_ctrl(ALUOP_JAL, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    o_jump = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_unit
// Brief   : Pipelined control unit: ID decode, load-use hazard detection,
//           EX/MEM/WB control registers and a saturating bubble counter.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int EXT_OPS = 0,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_ctrl_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    ctrl_t w_dec_ctrl;
    logic  w_use_rs1;
    logic  w_use_rs2;
    logic  w_dec_branch;
    logic  w_dec_jump;
    logic  w_hit;
    logic  w_stall;
    logic  w_bubble;
    logic  w_issue;

    logic              r_ex_valid;
    ctrl_t             r_ex_ctrl;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_mem_memread;
    logic              r_mem_memwrite;
    logic              r_mem_regwrite;
    logic              r_mem_memtoreg;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_wb_regwrite;
    logic              r_wb_memtoreg;
    logic [REG_AW-1:0] r_wb_rd;
    logic [CNT_W-1:0]  r_bubble_cnt;

    ctrl_decode #(
        .EXT_OPS (EXT_OPS),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .i_op      (bus.op_i),
        .o_ctrl    (w_dec_ctrl),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2),
        .o_branch  (w_dec_branch),
        .o_jump    (w_dec_jump)
    );

    // Flush and hold both mask the stall, so flush wins over a pending hazard.
    assign w_hit    = (w_use_rs1 && (bus.rs1_i == r_ex_rd)) ||
                      (w_use_rs2 && (bus.rs2_i == r_ex_rd));
    assign w_stall  = bus.valid_i && !bus.flush_i && !bus.hold_i &&
                      r_ex_ctrl.memread && (r_ex_rd != '0) && w_hit;
    assign w_bubble = !bus.valid_i || bus.flush_i || w_stall;
    assign w_issue  = bus.valid_i && !bus.flush_i && !w_stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_valid     <= 1'b0;
            r_ex_ctrl      <= CTRL_NOP;
            r_ex_rd        <= '0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_rd       <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_rd        <= '0;
            r_bubble_cnt   <= '0;
        end else if (!bus.hold_i) begin
            if (w_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= CTRL_NOP;
                r_ex_rd    <= '0;
                if (r_bubble_cnt != c_cnt_max) begin
                    r_bubble_cnt <= r_bubble_cnt + 1'b1;
                end
            end else begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= w_dec_ctrl;
                r_ex_rd    <= bus.rd_i;
            end
            r_mem_memread  <= r_ex_ctrl.memread;
            r_mem_memwrite <= r_ex_ctrl.memwrite;
            r_mem_regwrite <= r_ex_ctrl.regwrite;
            r_mem_memtoreg <= r_ex_ctrl.memtoreg;
            r_mem_rd       <= r_ex_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_rd        <= r_mem_rd;
        end
    end

    assign bus.stall_o        = w_stall;
    assign bus.branch_o       = w_dec_branch && w_issue;
    assign bus.jump_o         = w_dec_jump && w_issue;
    assign bus.ex_valid_o     = r_ex_valid;
    assign bus.ex_alusrc_o    = r_ex_ctrl.alusrc;
    assign bus.ex_illegal_o   = r_ex_ctrl.illegal;
    assign bus.ex_aluop_o     = ALUOP_W'(r_ex_ctrl.aluop);
    assign bus.ex_rd_o        = r_ex_rd;
    assign bus.mem_memread_o  = r_mem_memread;
    assign bus.mem_memwrite_o = r_mem_memwrite;
    assign bus.mem_regwrite_o = r_mem_regwrite;
    assign bus.mem_memtoreg_o = r_mem_memtoreg;
    assign bus.mem_rd_o       = r_mem_rd;
    assign bus.wb_regwrite_o  = r_wb_regwrite;
    assign bus.wb_memtoreg_o  = r_wb_memtoreg;
    assign bus.wb_rd_o        = r_wb_rd;
    assign bus.bubble_cnt_o   = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_ctrl_unit
// Brief   : Directed self-checking bench for pipe_ctrl_unit (base, extended
//           opcode and narrow-counter configurations).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    localparam logic [6:0] c_op_i   = 7'b0010011;
    localparam logic [6:0] c_op_r   = 7'b0110011;
    localparam logic [6:0] c_op_lw  = 7'b0000011;
    localparam logic [6:0] c_op_beq = 7'b1100011;
    localparam logic [6:0] c_op_lui = 7'b0110111;
    localparam logic [6:0] c_op_jal = 7'b1101111;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pipe_ctrl_unit_if #(.REG_AW(5), .ALUOP_W(2), .CNT_W(16)) bus_b ();
    pipe_ctrl_unit_if #(.REG_AW(5), .ALUOP_W(3), .CNT_W(16)) bus_e ();
    pipe_ctrl_unit_if #(.REG_AW(5), .ALUOP_W(2), .CNT_W(4))  bus_c ();

    pipe_ctrl_unit #(.ALUOP_W(2), .EXT_OPS(0), .REG_AW(5), .CNT_W(16)) u_base (
        .clk_i (clk), .rst_i (rst_n), .bus (bus_b));
    pipe_ctrl_unit #(.ALUOP_W(3), .EXT_OPS(1), .REG_AW(5), .CNT_W(16)) u_ext (
        .clk_i (clk), .rst_i (rst_n), .bus (bus_e));
    pipe_ctrl_unit #(.ALUOP_W(2), .EXT_OPS(0), .REG_AW(5), .CNT_W(4)) u_cnt (
        .clk_i (clk), .rst_i (rst_n), .bus (bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic fl, input logic hd);
        bus_b.valid_i = v;
        bus_b.op_i    = op;
        bus_b.rs1_i   = rs1;
        bus_b.rs2_i   = rs2;
        bus_b.rd_i    = rd;
        bus_b.flush_i = fl;
        bus_b.hold_i  = hd;
    endtask

    task automatic drive_e(input logic v, input logic [6:0] op, input logic [4:0] rd);
        bus_e.valid_i = v;
        bus_e.op_i    = op;
        bus_e.rs1_i   = 5'd0;
        bus_e.rs2_i   = 5'd0;
        bus_e.rd_i    = rd;
        bus_e.flush_i = 1'b0;
        bus_e.hold_i  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive_b(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive_e(1'b0, 7'd0, 5'd0);
        bus_c.valid_i = 1'b0; bus_c.op_i = 7'd0; bus_c.rs1_i = 5'd0; bus_c.rs2_i = 5'd0;
        bus_c.rd_i = 5'd0; bus_c.flush_i = 1'b0; bus_c.hold_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ex_valid", bus_b.ex_valid_o, 0);
        check_val("rst_cnt", bus_b.bubble_cnt_o, 0);
        check_val("rst_stall", bus_b.stall_o, 0);
        check_val("rst_wb_regwrite", bus_b.wb_regwrite_o, 0);

        // lw x5 then add x6,x5,x1: one stall cycle
        rst_n = 1'b1;
        drive_b(1'b1, c_op_lw, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        tick();
        drive_b(1'b1, c_op_r, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        #1;
        check_val("lu_stall", bus_b.stall_o, 1);
        check_val("lu_ex_lw_valid", bus_b.ex_valid_o, 1);
        tick();
        check_val("lu_bubble_valid", bus_b.ex_valid_o, 0);
        check_val("lu_stall_drop", bus_b.stall_o, 0);
        check_val("lu_cnt", bus_b.bubble_cnt_o, 1);
        check_val("lu_mem_memread", bus_b.mem_memread_o, 1);
        check_val("lu_mem_rd", bus_b.mem_rd_o, 5);
        tick();
        check_val("add_ex_valid", bus_b.ex_valid_o, 1);
        check_val("add_ex_rd", bus_b.ex_rd_o, 6);
        check_val("add_ex_aluop", bus_b.ex_aluop_o, 2);
        check_val("lw_wb_memtoreg", bus_b.wb_memtoreg_o, 1);
        check_val("lw_wb_rd", bus_b.wb_rd_o, 5);
        check_val("lu_cnt_after", bus_b.bubble_cnt_o, 1);

        // lw x0 then add x6,x0,x1: x0 never hazards
        drive_b(1'b1, c_op_lw, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive_b(1'b1, c_op_r, 5'd0, 5'd1, 5'd6, 1'b0, 1'b0);
        #1;
        check_val("x0_stall", bus_b.stall_o, 0);
        tick();
        check_val("x0_cnt", bus_b.bubble_cnt_o, 1);
        check_val("x0_ex_valid", bus_b.ex_valid_o, 1);

        // lw x5 then flushed beq using x5
        drive_b(1'b1, c_op_lw, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        tick();
        drive_b(1'b1, c_op_beq, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0);
        #1;
        check_val("fl_stall", bus_b.stall_o, 0);
        check_val("fl_branch", bus_b.branch_o, 0);
        tick();
        check_val("fl_ex_valid", bus_b.ex_valid_o, 0);
        check_val("fl_cnt", bus_b.bubble_cnt_o, 2);

        drive_b(1'b1, c_op_beq, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        #1;
        check_val("beq_branch", bus_b.branch_o, 1);
        check_val("beq_jump", bus_b.jump_o, 0);
        tick();
        check_val("beq_ex_aluop", bus_b.ex_aluop_o, 1);
        check_val("beq_ex_alusrc", bus_b.ex_alusrc_o, 0);

        // Fill: EX=lw x9, MEM=addi x7, WB=beq, then hold three cycles
        drive_b(1'b1, c_op_i, 5'd2, 5'd0, 5'd7, 1'b0, 1'b0);
        tick();
        check_val("addi_ex_alusrc", bus_b.ex_alusrc_o, 1);
        drive_b(1'b1, c_op_lw, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0);
        tick();
        drive_b(1'b1, c_op_r, 5'd9, 5'd1, 5'd10, 1'b0, 1'b1);
        #1;
        check_val("hold_stall", bus_b.stall_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("hold_ex_rd", bus_b.ex_rd_o, 9);
            check_val("hold_ex_valid", bus_b.ex_valid_o, 1);
            check_val("hold_mem_rd", bus_b.mem_rd_o, 7);
            check_val("hold_mem_regwrite", bus_b.mem_regwrite_o, 1);
            check_val("hold_wb_regwrite", bus_b.wb_regwrite_o, 0);
            check_val("hold_wb_rd", bus_b.wb_rd_o, 0);
            check_val("hold_cnt", bus_b.bubble_cnt_o, 2);
            check_val("hold_stall_in", bus_b.stall_o, 0);
        end
        drive_b(1'b1, c_op_r, 5'd9, 5'd1, 5'd10, 1'b0, 1'b0);
        #1;
        check_val("unhold_stall", bus_b.stall_o, 1);
        tick();
        check_val("unhold_ex_valid", bus_b.ex_valid_o, 0);
        check_val("unhold_cnt", bus_b.bubble_cnt_o, 3);
        check_val("unhold_mem_memread", bus_b.mem_memread_o, 1);
        check_val("unhold_mem_rd", bus_b.mem_rd_o, 9);
        check_val("unhold_wb_regwrite", bus_b.wb_regwrite_o, 1);
        check_val("unhold_wb_rd", bus_b.wb_rd_o, 7);
        tick();
        check_val("add2_ex_rd", bus_b.ex_rd_o, 10);

        // lui: illegal on base, decoded on extended build
        drive_b(1'b1, c_op_lui, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        drive_e(1'b1, c_op_lui, 5'd4);
        tick();
        check_val("lui_b_illegal", bus_b.ex_illegal_o, 1);
        check_val("lui_b_aluop", bus_b.ex_aluop_o, 0);
        check_val("lui_b_alusrc", bus_b.ex_alusrc_o, 0);
        check_val("lui_b_valid", bus_b.ex_valid_o, 1);
        check_val("lui_e_aluop", bus_e.ex_aluop_o, 4);
        check_val("lui_e_alusrc", bus_e.ex_alusrc_o, 1);
        check_val("lui_e_illegal", bus_e.ex_illegal_o, 0);
        drive_b(1'b1, c_op_jal, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
        drive_e(1'b1, c_op_jal, 5'd1);
        #1;
        check_val("jal_e_jump", bus_e.jump_o, 1);
        check_val("jal_b_jump", bus_b.jump_o, 0);
        tick();
        check_val("lui_b_mem_regwrite", bus_b.mem_regwrite_o, 0);
        check_val("jal_e_aluop", bus_e.ex_aluop_o, 5);
        drive_b(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drive_e(1'b0, 7'd0, 5'd0);
        tick();
        check_val("lui_e_wb_regwrite", bus_e.wb_regwrite_o, 1);
        check_val("lui_e_wb_rd", bus_e.wb_rd_o, 4);

        // Narrow counter: saturation and asynchronous reset
        check_val("cnt_sat", bus_c.bubble_cnt_o, 15);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("cnt_async_rst_sat", bus_c.bubble_cnt_o, 0);
        check_val("base_async_rst_valid", bus_b.ex_valid_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        check_val("cnt_five", bus_c.bubble_cnt_o, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("cnt_async_rst_mid", bus_c.bubble_cnt_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
